// File: rtl/phase_incr_estimator_pkg.sv
// phase_incr_estimator_pkg: shared widths, state encoding and sample type for the
// phase-increment estimator. Revision 1.0
`default_nettype none

package phase_incr_estimator_pkg;

  localparam int SAMPLE_W = 32;
  localparam int PHASE_W  = 32;

  typedef enum logic [0:0] {
    SEEK    = 1'b0,
    MEASURE = 1'b1
  } est_state_t;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

`default_nettype wire

// File: rtl/phase_incr_estimator_if.sv
// phase_incr_estimator_if: sample stream in, phase-increment estimate out.
// Revision 1.0
`default_nettype none

interface phase_incr_estimator_if #(
  parameter int SAMPLE_W = 32,
  parameter int PERIOD_W = 24
);
  import phase_incr_estimator_pkg::*;

  logic                       step_in;
  logic signed [SAMPLE_W-1:0] sample_in;
  logic [PHASE_W-1:0]         phase_incr_out;
  logic [PERIOD_W-1:0]        period_out;
  logic                       valid_out;
  logic                       locked_out;

  modport master (
    output step_in, sample_in,
    input  phase_incr_out, period_out, valid_out, locked_out
  );

  modport slave (
    input  step_in, sample_in,
    output phase_incr_out, period_out, valid_out, locked_out
  );

endinterface

`default_nettype wire

// File: rtl/phase_incr_estimator_recip_divider.sv
// recip_divider: restoring serial divider computing floor(2^PHASE_W / divisor),
// one quotient bit per clock. Revision 1.0
`default_nettype none

module recip_divider
  import phase_incr_estimator_pkg::*;
#(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [PERIOD_W-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic [PHASE_W-1:0]  quotient
);

  localparam logic [5:0] NUM_BITS = 6'(PHASE_W + 1);

  logic [PERIOD_W-1:0] dvsr;
  logic [PERIOD_W-1:0] rem;
  logic [PHASE_W:0]    dividend;
  logic [PHASE_W-1:0]  quo;
  logic [5:0]          bits_left;
  logic                busy_q;
  logic                done_q;

  logic [PERIOD_W:0]   shifted;
  logic                fits;
  logic [PERIOD_W-1:0] rem_next;

  // The remainder is always below the divisor, so one extra bit covers the shift.
  always_comb begin
    shifted  = {rem, dividend[PHASE_W]};
    fits     = shifted >= {1'b0, dvsr};
    rem_next = fits ? PERIOD_W'(shifted - {1'b0, dvsr}) : shifted[PERIOD_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      dvsr      <= '0;
      rem       <= '0;
      dividend  <= '0;
      quo       <= '0;
      bits_left <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (start) begin
      dvsr      <= divisor;
      rem       <= '0;
      dividend  <= {1'b1, {PHASE_W{1'b0}}};
      quo       <= '0;
      bits_left <= NUM_BITS;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (busy_q) begin
        rem       <= rem_next;
        dividend  <= {dividend[PHASE_W-1:0], 1'b0};
        quo       <= {quo[PHASE_W-2:0], fits};
        bits_left <= bits_left - 6'd1;
        if (bits_left == 6'd1) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo;

endmodule

`default_nettype wire

// File: rtl/phase_incr_estimator.sv
// phase_incr_estimator: measures the period between rising zero crossings (with
// hysteresis) and reports floor(2^32 / period) as a DDS phase increment. Revision 1.0
`default_nettype none

module phase_incr_estimator #(
  parameter int SAMPLE_W   = 32,
  parameter int PERIOD_W   = 24,
  parameter int HYST       = 2**20,
  parameter int MIN_PERIOD = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  phase_incr_estimator_if.slave   est
);
  import phase_incr_estimator_pkg::*;

  localparam logic [0:0]                 ST_SEEK    = 1'b0;
  localparam logic [0:0]                 ST_MEASURE = 1'b1;
  localparam logic [PERIOD_W-1:0]        COUNT_MAX  = '1;
  localparam logic [PERIOD_W-1:0]        MIN_P      = PERIOD_W'(MIN_PERIOD);
  localparam logic signed [SAMPLE_W-1:0] NEG_HYST   = -SAMPLE_W'(HYST);

  logic [0:0]          state;
  logic                armed;
  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] pend_period;
  logic [PHASE_W-1:0]  phase_incr;
  logic [PERIOD_W-1:0] period;
  logic                valid;
  logic                locked;

  logic                below_hyst;
  logic                crossing;
  logic                timeout;
  logic                launch;
  logic [PERIOD_W-1:0] period_p;
  logic                div_busy;
  logic                div_done;
  logic [PHASE_W-1:0]  div_quotient;

  // Timeout fires only on the step that brings count to its ceiling, so a
  // saturated counter in SEEK does not keep disarming the detector.
  always_comb begin
    below_hyst = est.sample_in < NEG_HYST;
    crossing   = est.step_in && armed && !est.sample_in[SAMPLE_W-1];
    period_p   = count + PERIOD_W'(1);
    timeout    = est.step_in && !crossing && (count == COUNT_MAX - PERIOD_W'(1));
    launch     = crossing && (state == ST_MEASURE) && (period_p >= MIN_P) && !div_busy;
  end

  recip_divider #(
    .PERIOD_W (PERIOD_W)
  ) u_div (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .start    (launch),
    .abort    (timeout),
    .divisor  (period_p),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state       <= ST_SEEK;
      armed       <= 1'b0;
      count       <= '0;
      pend_period <= '0;
      phase_incr  <= '0;
      period      <= '0;
      valid       <= 1'b0;
      locked      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (div_done) begin
        phase_incr <= div_quotient;
        period     <= pend_period;
        valid      <= 1'b1;
        locked     <= 1'b1;
      end
      if (est.step_in) begin
        if (crossing) begin
          armed <= 1'b0;
          count <= '0;
          if (state == ST_SEEK) begin
            state <= ST_MEASURE;
          end else if (launch) begin
            pend_period <= period_p;
          end
        end else begin
          if (below_hyst) begin
            armed <= 1'b1;
          end
          if (count != COUNT_MAX) begin
            count <= count + PERIOD_W'(1);
          end
          if (timeout) begin
            locked <= 1'b0;
            state  <= ST_SEEK;
            armed  <= 1'b0;
          end
        end
      end
    end
  end

  assign est.phase_incr_out = phase_incr;
  assign est.period_out     = period;
  assign est.valid_out      = valid;
  assign est.locked_out     = locked;

endmodule

`default_nettype wire

// File: tb/tb_phase_incr_estimator.sv
// tb_phase_incr_estimator: scoreboard bench; a behavioural model queues expected
// estimates at each crossing and the monitor compares them when valid_out fires.
`default_nettype none

module tb_phase_incr_estimator;
  import phase_incr_estimator_pkg::*;

  localparam int PW     = 10;
  localparam int HYST   = 500;
  localparam int CMAX   = 2**PW - 1;
  localparam int LAT    = 34;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               step = 1'b0;
  logic signed [31:0] sample = '0;

  always #5 clk = ~clk;

  phase_incr_estimator_if #(.SAMPLE_W(32), .PERIOD_W(PW)) if_a ();
  phase_incr_estimator_if #(.SAMPLE_W(32), .PERIOD_W(PW)) if_b ();

  assign if_a.step_in   = step;
  assign if_a.sample_in = sample;
  assign if_b.step_in   = step;
  assign if_b.sample_in = sample;

  phase_incr_estimator #(
    .SAMPLE_W(32), .PERIOD_W(PW), .HYST(HYST), .MIN_PERIOD(2)
  ) u_dut (
    .clk_in(clk), .rst_n_in(rst_n), .est(if_a.slave)
  );

  phase_incr_estimator #(
    .SAMPLE_W(32), .PERIOD_W(PW), .HYST(HYST), .MIN_PERIOD(3)
  ) u_dut_min3 (
    .clk_in(clk), .rst_n_in(rst_n), .est(if_b.slave)
  );

  typedef struct {
    logic [31:0]   phase;
    logic [PW-1:0] period;
    longint        due;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  longint        cyc      = 0;
  int            a_valids = 0;
  int            b_valids = 0;

  bit            m_armed  = 1'b0;
  int            m_count  = 0;
  bit            m_seek   = 1'b1;
  bit            m_locked = 1'b0;
  bit            m_valid  = 1'b0;
  logic [31:0]   m_phase  = '0;
  logic [PW-1:0] m_period = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_checks++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, req, cyc);
    end
  endtask

  // Reference model evaluated on each rising edge, then DUT outputs compared 1 ns later.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      m_valid = 1'b0;
      if (!rst_n) begin
        m_armed = 1'b0; m_count = 0; m_seek = 1'b1; m_locked = 1'b0;
        m_phase = '0; m_period = '0;
        sb.delete();
      end else begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
          m_valid  = 1'b1;
          m_phase  = sb[0].phase;
          m_period = sb[0].period;
          m_locked = 1'b1;
          void'(sb.pop_front());
        end
        if (step) begin
          if (m_armed && sample >= 0) begin
            automatic int p = m_count + 1;
            m_count = 0;
            m_armed = 1'b0;
            if (m_seek) begin
              m_seek = 1'b0;
            end else if (p >= 2 && sb.size() == 0) begin
              automatic exp_t e;
              e.phase  = 32'(64'h1_0000_0000 / longint'(p));
              e.period = PW'(p);
              e.due    = cyc + LAT;
              sb.push_back(e);
            end
          end else begin
            if (sample < -HYST) m_armed = 1'b1;
            if (m_count < CMAX) begin
              m_count++;
              if (m_count == CMAX) begin
                m_locked = 1'b0;
                m_seek   = 1'b1;
                m_armed  = 1'b0;
                sb.delete();
              end
            end
          end
        end
      end
      #1;
      check("valid_out",      64'(if_a.valid_out),      64'(m_valid));
      check("locked_out",     64'(if_a.locked_out),     64'(m_locked));
      check("phase_incr_out", 64'(if_a.phase_incr_out), 64'(m_phase));
      check("period_out",     64'(if_a.period_out),     64'(m_period));
      if (if_a.valid_out) a_valids++;
      if (if_b.valid_out) b_valids++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    step  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One sample strobe, then gap-1 idle clocks (gap >= 2).
  task automatic drive(input int val, input int gap);
    @(negedge clk);
    step   = 1'b1;
    sample = 32'(val);
    @(negedge clk);
    step = 1'b0;
    repeat (gap - 2) @(negedge clk);
  endtask

  task automatic square(input int amp, input int n_periods, input int gap);
    for (int k = 0; k < n_periods; k++) begin
      for (int i = 0; i < 5; i++) drive(-amp, gap);
      for (int i = 0; i < 5; i++) drive(amp, gap);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] ph;
    real         s;

    repeat (3) @(negedge clk);
    check("reset_valid",  64'(if_a.valid_out),      64'd0);
    check("reset_locked", 64'(if_a.locked_out),     64'd0);
    check("reset_phase",  64'(if_a.phase_incr_out), 64'd0);
    check("reset_period", 64'(if_a.period_out),     64'd0);
    rst_n = 1'b1;

    // Sine at phase increment 2^24, one sample every 4 clocks.
    a_valids = 0;
    ph = '0;
    for (int i = 0; i <= 1024; i++) begin
      s = $sin(2.0 * 3.14159265358979 * real'(ph) / 4294967296.0) * 1073741824.0;
      drive($rtoi(s), 4);
      ph = ph + 32'h0100_0000;
    end
    idle(LAT + 6);
    check("sine_valids", 64'(a_valids),            64'd3);
    check("sine_phase",  64'(if_a.phase_incr_out), 64'd16777216);
    check("sine_period", 64'(if_a.period_out),     64'd256);
    check("sine_locked", 64'(if_a.locked_out),     64'd1);

    // Square wave period 10, amplitude above hysteresis.
    do_reset();
    a_valids = 0;
    square(1000, 4, 4);
    idle(LAT + 6);
    check("sq_valids", 64'(a_valids),            64'd3);
    check("sq_phase",  64'(if_a.phase_incr_out), 64'd429496729);
    check("sq_period", 64'(if_a.period_out),     64'd10);
    check("sq_locked", 64'(if_a.locked_out),     64'd1);

    // Square below hysteresis never arms.
    do_reset();
    a_valids = 0;
    square(400, 4, 4);
    idle(LAT + 6);
    check("small_valids", 64'(a_valids),        64'd0);
    check("small_locked", 64'(if_a.locked_out), 64'd0);

    // Lock, then hold a positive level until the period counter times out.
    do_reset();
    square(1000, 2, 4);
    for (int i = 0; i < 20; i++) drive(1000, 4);
    check("hold_locked_pre", 64'(if_a.locked_out), 64'd1);
    for (int i = 0; i < CMAX + 10; i++) drive(1000, 4);
    check("to_locked", 64'(if_a.locked_out),     64'd0);
    check("to_phase",  64'(if_a.phase_incr_out), 64'd429496729);
    check("to_period", 64'(if_a.period_out),     64'd10);

    // Reset 10 clocks into a divide: nothing may come out.
    do_reset();
    a_valids = 0;
    for (int i = 0; i < 5; i++) drive(-1000, 4);
    drive(1000, 4);
    for (int i = 0; i < 5; i++) drive(-1000, 4);
    drive(1000, 2);
    idle(9);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_phase",  64'(if_a.phase_incr_out), 64'd0);
    check("rst_period", 64'(if_a.period_out),     64'd0);
    idle(LAT + 26);
    check("rst_valids", 64'(a_valids),            64'd0);
    check("rst_locked", 64'(if_a.locked_out),     64'd0);

    // Shortest period: alternate every sample; MIN_PERIOD=3 instance must stay silent.
    do_reset();
    a_valids = 0;
    b_valids = 0;
    for (int i = 0; i < 10; i++) begin
      drive(-1000, 20);
      drive(1000, 20);
    end
    idle(LAT + 6);
    check("p2_valids",      64'(a_valids),            64'd9);
    check("p2_phase",       64'(if_a.phase_incr_out), 64'd2147483648);
    check("p2_period",      64'(if_a.period_out),     64'd2);
    check("min3_valids",    64'(b_valids),            64'd0);
    check("min3_locked",    64'(if_b.locked_out),     64'd0);
    check("sb_drained",     64'(sb.size()),           64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
